// File: rtl/pc_pkg.sv
// Shared types for the next-PC predictor: 2-bit counter states, opcode
// constants and the saturating counter update.
package pc_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_JAL = 5'b00011;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] OP_BLT = 5'b00110;
    localparam logic [4:0] OP_BEX = 5'b10110;

    // Saturating step toward taken (ST) or not-taken (SNT).
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        if (taken) begin
            return (cur == ST) ? ST : ctr_t'(cur + 2'd1);
        end
        return (cur == SNT) ? SNT : ctr_t'(cur - 2'd1);
    endfunction

endpackage

// File: rtl/btb_bank.sv
// Direct-mapped branch target buffer storage: combinational read ports,
// one synchronous write port, valid bits cleared on synchronous reset.
module btb_bank
    import pc_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int RD_PORTS = 2,
    localparam int IDX     = $clog2(ENTRIES),
    localparam int TAG_W   = XLEN - IDX
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [RD_PORTS-1:0][IDX-1:0]    rd_idx,
    output logic [RD_PORTS-1:0]             rd_valid,
    output logic [RD_PORTS-1:0][TAG_W-1:0]  rd_tag,
    output logic [RD_PORTS-1:0][XLEN-1:0]   rd_target,
    output ctr_t                            rd_ctr [RD_PORTS],
    input  logic                            wr_en,
    input  logic [IDX-1:0]                  wr_idx,
    input  logic [TAG_W-1:0]                wr_tag,
    input  logic [XLEN-1:0]                 wr_target,
    input  ctr_t                            wr_ctr
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        ctr_t             ctr;
    } btb_entry_t;

    btb_entry_t mem [ENTRIES];

    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_valid[p]  = mem[rd_idx[p]].valid;
            rd_tag[p]    = mem[rd_idx[p]].tag;
            rd_target[p] = mem[rd_idx[p]].target;
            rd_ctr[p]    = mem[rd_idx[p]].ctr;
        end
    end

    // NOTE: only the valid bits are reset; tag/target/ctr are don't-care
    // until an entry is allocated, so they need no reset network.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: wr_ctr};
        end
    end

endmodule

// File: rtl/pc_predict_unit.sv
// Next-PC generator: fetch PC register, BTB-based prediction, mispredict
// redirect/flush and saturating mispredict counter. BTB present only when
// PC_PREDICT_BHT_EN is defined; otherwise fetch always predicts PC+1.
module pc_predict_unit
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            fetch_stall,
    output logic [XLEN-1:0] fetch_pc,
    output logic            fetch_pred_taken,
    output logic [XLEN-1:0] fetch_pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_cond,
    input  logic            ex_is_uncond,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            flush,
    output logic [31:0]     mispredict_count
);

    if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_depth
        $error("BTB_ENTRIES must be a power of two and at least 2");
    end

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus1;
    logic [XLEN-1:0] correct_pc;
    logic            flush_q;
    logic [31:0]     mis_cnt_q;
    logic            resolve;
    logic            mispredict;

    assign pc_plus1   = pc_q + XLEN'(1);
    assign resolve    = ex_valid && (ex_is_cond || ex_is_uncond);
    assign correct_pc = ex_taken ? ex_target : ex_pc + XLEN'(1);
    assign mispredict = resolve && ((ex_pred_taken != ex_taken) ||
                        (ex_taken && ex_pred_taken && (ex_pred_target != ex_target)));

`ifdef PC_PREDICT_BHT_EN
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX;

    logic [1:0][IDX-1:0]   rd_idx;
    logic [1:0]            rd_valid;
    logic [1:0][TAG_W-1:0] rd_tag;
    logic [1:0][XLEN-1:0]  rd_target;
    ctr_t                  rd_ctr [2];
    logic                  wr_en;
    logic [IDX-1:0]        wr_idx;
    logic [TAG_W-1:0]      wr_tag;
    logic [XLEN-1:0]       wr_target;
    ctr_t                  wr_ctr;
    logic                  fetch_hit;
    logic                  ex_hit;

    // Port 0 serves the fetch lookup, port 1 reads the resolving entry.
    assign rd_idx[0] = pc_q[IDX-1:0];
    assign rd_idx[1] = ex_pc[IDX-1:0];
    assign fetch_hit = rd_valid[0] && (rd_tag[0] == pc_q[XLEN-1:IDX]);
    assign ex_hit    = rd_valid[1] && (rd_tag[1] == ex_pc[XLEN-1:IDX]);

    assign fetch_pred_taken  = fetch_hit && (rd_ctr[0] == WT || rd_ctr[0] == ST);
    assign fetch_pred_target = fetch_pred_taken ? rd_target[0] : pc_plus1;

    // NOTE: every output of this always_comb gets a default first, so no
    // path through the branches leaves a signal unassigned (no latches).
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = ex_pc[IDX-1:0];
        wr_tag    = ex_pc[XLEN-1:IDX];
        wr_target = ex_target;
        wr_ctr    = ST;
        if (resolve) begin
            if (ex_hit) begin
                wr_en = 1'b1;
                if (!ex_is_uncond) begin
                    wr_ctr = ctr_next(rd_ctr[1], ex_taken);
                    if (!ex_taken) wr_target = rd_target[1];
                end
            end else if (ex_taken) begin
                wr_en  = 1'b1;
                wr_ctr = ex_is_uncond ? ST : WT;
            end
        end
    end

    btb_bank #(
        .XLEN     (XLEN),
        .ENTRIES  (BTB_ENTRIES),
        .RD_PORTS (2)
    ) u_btb (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .rd_ctr    (rd_ctr),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_tag    (wr_tag),
        .wr_target (wr_target),
        .wr_ctr    (wr_ctr)
    );
`else
    assign fetch_pred_taken  = 1'b0;
    assign fetch_pred_target = pc_plus1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q      <= RESET_PC;
            flush_q   <= 1'b0;
            mis_cnt_q <= '0;
        end else begin
            flush_q <= mispredict;
            if (mispredict) begin
                pc_q <= correct_pc;
            end else if (!fetch_stall) begin
                pc_q <= fetch_pred_target;
            end
            if (mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) begin
                mis_cnt_q <= mis_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_pc         = pc_q;
    assign flush            = flush_q;
    assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed self-checking bench for pc_predict_unit; expectations follow
// PC_PREDICT_BHT_EN so the same bench covers both builds.
module tb_pc_predict_unit;

`ifdef PC_PREDICT_BHT_EN
    localparam bit BHT = 1'b1;
`else
    localparam bit BHT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_stall = 1'b0;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
    logic [31:0] fetch_pred_target;
    logic        ex_valid = 1'b0;
    logic        ex_is_cond = 1'b0;
    logic        ex_is_uncond = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        flush;
    logic [31:0] mispredict_count;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_cnt = '0;

    pc_predict_unit #(
        .XLEN        (32),
        .BTB_ENTRIES (16),
        .RESET_PC    (32'h0)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .fetch_stall       (fetch_stall),
        .fetch_pc          (fetch_pc),
        .fetch_pred_taken  (fetch_pred_taken),
        .fetch_pred_target (fetch_pred_target),
        .ex_valid          (ex_valid),
        .ex_is_cond        (ex_is_cond),
        .ex_is_uncond      (ex_is_uncond),
        .ex_pc             (ex_pc),
        .ex_taken          (ex_taken),
        .ex_target         (ex_target),
        .ex_pred_taken     (ex_pred_taken),
        .ex_pred_target    (ex_pred_target),
        .flush             (flush),
        .mispredict_count  (mispredict_count)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic resolve(input logic cond, input logic uncond, input logic [31:0] pc,
                           input logic taken, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_is_cond     = cond;
        ex_is_uncond   = uncond;
        ex_pc          = pc;
        ex_taken       = taken;
        ex_target      = tgt;
        ex_pred_taken  = ptaken;
        ex_pred_target = ptgt;
    endtask

    task automatic idle;
        ex_valid      = 1'b0;
        ex_is_cond    = 1'b0;
        ex_is_uncond  = 1'b0;
        ex_taken      = 1'b0;
        ex_pred_taken = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle();
        tick();
        tick();
        n_vec++; if (fetch_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", fetch_pc, 32'h0); end
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", flush); end
        n_vec++; if (mispredict_count !== 32'h0) begin n_err++; $display("FAIL reset_count: got %0d want 0", mispredict_count); end
        n_vec++; if (fetch_pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred: got %b want 0", fetch_pred_taken); end
        n_vec++; if (fetch_pred_target !== 32'h1) begin n_err++; $display("FAIL reset_target: got %h want 1", fetch_pred_target); end
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_vec++; if (fetch_pc !== 32'(i)) begin n_err++; $display("FAIL free_run_pc: got %h want %h", fetch_pc, 32'(i)); end
            n_vec++; if (flush !== 1'b0 || fetch_pred_taken !== 1'b0) begin
                n_err++; $display("FAIL free_run_flags: flush %b pred %b want 0 0", flush, fetch_pred_taken);
            end
        end
    endtask

    task automatic test_cond_taken;
        resolve(1'b1, 1'b0, 32'd5, 1'b1, 32'h40, 1'b0, 32'd6);
        tick();
        idle();
        exp_cnt++;
        n_vec++; if (fetch_pc !== 32'h40) begin n_err++; $display("FAIL taken_redirect: got %h want %h", fetch_pc, 32'h40); end
        n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL taken_flush: got %b want 1", flush); end
        n_vec++; if (mispredict_count !== exp_cnt) begin n_err++; $display("FAIL taken_count: got %0d want %0d", mispredict_count, exp_cnt); end
        tick();
        n_vec++; if (fetch_pc !== 32'h41 || flush !== 1'b0) begin
            n_err++; $display("FAIL flush_one_cycle: pc %h flush %b want 41 0", fetch_pc, flush);
        end
        resolve(1'b0, 1'b1, 32'h20, 1'b1, 32'd5, 1'b0, 32'h21);
        tick();
        idle();
        exp_cnt++;
        n_vec++; if (fetch_pc !== 32'd5) begin n_err++; $display("FAIL jump_to_5: got %h want 5", fetch_pc); end
        n_vec++; if (fetch_pred_taken !== BHT) begin n_err++; $display("FAIL pred_taken_pc5: got %b want %b", fetch_pred_taken, BHT); end
        n_vec++; if (fetch_pred_target !== (BHT ? 32'h40 : 32'd6)) begin
            n_err++; $display("FAIL pred_target_pc5: got %h want %h", fetch_pred_target, BHT ? 32'h40 : 32'd6);
        end
    endtask

    task automatic test_cond_not_taken;
        resolve(1'b1, 1'b0, 32'd5, 1'b0, 32'h0, 1'b1, 32'h40);
        #1;
        n_vec++; if (fetch_pred_taken !== BHT) begin n_err++; $display("FAIL no_bypass: got %b want %b", fetch_pred_taken, BHT); end
        tick();
        exp_cnt++;
        n_vec++; if (fetch_pc !== 32'd6 || flush !== 1'b1) begin
            n_err++; $display("FAIL nt_redirect_1: pc %h flush %b want 6 1", fetch_pc, flush);
        end
        tick();
        exp_cnt++;
        idle();
        n_vec++; if (fetch_pc !== 32'd6 || flush !== 1'b1) begin
            n_err++; $display("FAIL nt_redirect_2: pc %h flush %b want 6 1", fetch_pc, flush);
        end
        n_vec++; if (mispredict_count !== exp_cnt) begin n_err++; $display("FAIL nt_count: got %0d want %0d", mispredict_count, exp_cnt); end
        resolve(1'b0, 1'b1, 32'h21, 1'b1, 32'd5, 1'b0, 32'h22);
        tick();
        idle();
        exp_cnt++;
        n_vec++; if (fetch_pc !== 32'd5) begin n_err++; $display("FAIL back_to_5: got %h want 5", fetch_pc); end
        n_vec++; if (fetch_pred_taken !== 1'b0 || fetch_pred_target !== 32'd6) begin
            n_err++; $display("FAIL ctr_decayed: pred %b target %h want 0 6", fetch_pred_taken, fetch_pred_target);
        end
    endtask

    task automatic test_alias;
        resolve(1'b1, 1'b0, 32'd3, 1'b1, 32'h50, 1'b0, 32'd4);
        tick();
        exp_cnt++;
        n_vec++; if (fetch_pc !== 32'h50) begin n_err++; $display("FAIL alias_first: got %h want 50", fetch_pc); end
        resolve(1'b1, 1'b0, 32'd19, 1'b1, 32'h60, 1'b0, 32'd20);
        tick();
        exp_cnt++;
        n_vec++; if (fetch_pc !== 32'h60 || flush !== 1'b1) begin
            n_err++; $display("FAIL alias_second: pc %h flush %b want 60 1", fetch_pc, flush);
        end
        resolve(1'b0, 1'b1, 32'h28, 1'b1, 32'd19, 1'b0, 32'h29);
        tick();
        idle();
        exp_cnt++;
        n_vec++; if (fetch_pc !== 32'd19) begin n_err++; $display("FAIL alias_goto_19: got %h want 13", fetch_pc); end
        n_vec++; if (fetch_pred_taken !== BHT || fetch_pred_target !== (BHT ? 32'h60 : 32'd20)) begin
            n_err++; $display("FAIL alias_pred_19: pred %b target %h want %b %h", fetch_pred_taken,
                              fetch_pred_target, BHT, BHT ? 32'h60 : 32'd20);
        end
        resolve(1'b0, 1'b1, 32'h22, 1'b1, 32'd3, 1'b0, 32'h23);
        tick();
        idle();
        exp_cnt++;
        n_vec++; if (fetch_pc !== 32'd3) begin n_err++; $display("FAIL alias_goto_3: got %h want 3", fetch_pc); end
        n_vec++; if (fetch_pred_taken !== 1'b0 || fetch_pred_target !== 32'd4) begin
            n_err++; $display("FAIL alias_evicted: pred %b target %h want 0 4", fetch_pred_taken, fetch_pred_target);
        end
        n_vec++; if (mispredict_count !== exp_cnt) begin n_err++; $display("FAIL alias_count: got %0d want %0d", mispredict_count, exp_cnt); end
    endtask

    task automatic test_stall;
        fetch_stall = 1'b1;
        resolve(1'b0, 1'b1, 32'h29, 1'b1, 32'h70, 1'b0, 32'h2a);
        tick();
        idle();
        exp_cnt++;
        n_vec++; if (fetch_pc !== 32'h70 || flush !== 1'b1) begin
            n_err++; $display("FAIL stall_redirect: pc %h flush %b want 70 1", fetch_pc, flush);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (fetch_pc !== 32'h70 || flush !== 1'b0) begin
                n_err++; $display("FAIL stall_hold: pc %h flush %b want 70 0", fetch_pc, flush);
            end
        end
        fetch_stall = 1'b0;
        tick();
        n_vec++; if (fetch_pc !== 32'h71) begin n_err++; $display("FAIL stall_release: got %h want 71", fetch_pc); end
    endtask

    task automatic test_back_to_back;
        resolve(1'b0, 1'b1, 32'h2a, 1'b1, 32'h100, 1'b0, 32'h2b);
        tick();
        exp_cnt++;
        n_vec++; if (fetch_pc !== 32'h100 || flush !== 1'b1) begin
            n_err++; $display("FAIL b2b_first: pc %h flush %b want 100 1", fetch_pc, flush);
        end
        resolve(1'b1, 1'b0, 32'h2b, 1'b0, 32'h0, 1'b1, 32'h200);
        tick();
        idle();
        exp_cnt++;
        n_vec++; if (fetch_pc !== 32'h2c || flush !== 1'b1) begin
            n_err++; $display("FAIL b2b_second: pc %h flush %b want 2c 1", fetch_pc, flush);
        end
        n_vec++; if (mispredict_count !== exp_cnt) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", mispredict_count, exp_cnt); end
        tick();
        n_vec++; if (fetch_pc !== 32'h2d || flush !== 1'b0) begin
            n_err++; $display("FAIL b2b_after: pc %h flush %b want 2d 0", fetch_pc, flush);
        end
    endtask

    task automatic test_ignored;
        resolve(1'b0, 1'b0, 32'h2d, 1'b1, 32'h300, 1'b0, 32'h2e);
        tick();
        n_vec++; if (fetch_pc !== 32'h2e || flush !== 1'b0) begin
            n_err++; $display("FAIL non_ctrl_ignored: pc %h flush %b want 2e 0", fetch_pc, flush);
        end
        resolve(1'b1, 1'b0, 32'h2e, 1'b1, 32'h300, 1'b0, 32'h2f);
        ex_valid = 1'b0;
        tick();
        n_vec++; if (fetch_pc !== 32'h2f || flush !== 1'b0) begin
            n_err++; $display("FAIL invalid_ignored: pc %h flush %b want 2f 0", fetch_pc, flush);
        end
        resolve(1'b1, 1'b0, 32'h2e, 1'b1, 32'h400, 1'b1, 32'h400);
        tick();
        idle();
        n_vec++; if (fetch_pc !== 32'h30 || flush !== 1'b0) begin
            n_err++; $display("FAIL correct_pred: pc %h flush %b want 30 0", fetch_pc, flush);
        end
        n_vec++; if (mispredict_count !== exp_cnt) begin n_err++; $display("FAIL ignored_count: got %0d want %0d", mispredict_count, exp_cnt); end
    endtask

    task automatic test_jump_pred;
        resolve(1'b0, 1'b1, 32'd2, 1'b1, 32'h10, 1'b0, 32'd3);
        tick();
        exp_cnt++;
        n_vec++; if (fetch_pc !== 32'h10 || flush !== 1'b1) begin
            n_err++; $display("FAIL j_redirect: pc %h flush %b want 10 1", fetch_pc, flush);
        end
        resolve(1'b0, 1'b1, 32'h2f, 1'b1, 32'd2, 1'b0, 32'h30);
        tick();
        idle();
        exp_cnt++;
        n_vec++; if (fetch_pc !== 32'd2) begin n_err++; $display("FAIL j_goto_2: got %h want 2", fetch_pc); end
        n_vec++; if (fetch_pred_taken !== BHT || fetch_pred_target !== (BHT ? 32'h10 : 32'd3)) begin
            n_err++; $display("FAIL j_pred_2: pred %b target %h want %b %h", fetch_pred_taken,
                              fetch_pred_target, BHT, BHT ? 32'h10 : 32'd3);
        end
        n_vec++; if (mispredict_count !== exp_cnt) begin n_err++; $display("FAIL final_count: got %0d want %0d", mispredict_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_cond_taken();
        test_cond_not_taken();
        test_alias();
        test_stall();
        test_back_to_back();
        test_ignored();
        test_jump_pred();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
